spi_slave_responder: RTL and testbench

SPI mode-0 responder (target side) for the FPGA fabric: the other end of the Qsys SPI masters that drive the ADC and CAN chip-selects. It lets an external SPI master (or an FPGA-side master looped back through GPIO) exchange words with fabric logic. SCLK, MOSI and SS_n are oversampled in the system clock domain. A one-word transmit holding register and a one-cycle receive strobe give the fabric a simple byte-stream interface.

---
 rtl/spi_slave_responder.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversampled pins, one-word TX holding register,
// one-cycle RX strobe.
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   spi_sclk/mosi/ss_n  asynchronous SPI pins from the master
//   spi_miso, _oe       slave-out data and its enable (high while selected)
//   tx_data/valid/ready holding-register write handshake
//   rx_data, rx_valid   last complete word and its one-cycle strobe
//   tx_underrun         pulse when FILL was loaded instead of user data
//   frame_active        synchronized, inverted SS_n
module spi_slave_responder #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_ss_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_active
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // Two sync stages per pin; the third stage on sclk/ss_n is the
  // previous value for edge detection.
  logic sclk_q1, sclk_q2, sclk_q3;
  logic ss_q1, ss_q2, ss_q3;
  logic mosi_q1, mosi_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q1 <= 1'b0;
      sclk_q2 <= 1'b0;
      sclk_q3 <= 1'b0;
      ss_q1   <= 1'b1;
      ss_q2   <= 1'b1;
      ss_q3   <= 1'b1;
      mosi_q1 <= 1'b0;
      mosi_q2 <= 1'b0;
    end else begin
      sclk_q1 <= spi_sclk;
      sclk_q2 <= sclk_q1;
      sclk_q3 <= sclk_q2;
      ss_q1   <= spi_ss_n;
      ss_q2   <= ss_q1;
      ss_q3   <= ss_q2;
      mosi_q1 <= spi_mosi;
      mosi_q2 <= mosi_q1;
    end
  end

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_rise = sclk_q2 & ~sclk_q3;
  assign sclk_fall = ~sclk_q2 & sclk_q3;
  assign ss_fall   = ~ss_q2 & ss_q3;
  assign ss_rise   = ss_q2 & ~ss_q3;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sin_q, sin_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic             word_done_q, word_done_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             unr_q, unr_d;
  logic             load;
  logic             wr;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    word_done_d = word_done_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    unr_d       = 1'b0;
    load        = 1'b0;
    wr          = tx_valid & ~hold_full_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          load        = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
        end else if (sclk_rise) begin
          sin_d     = {sin_q[WIDTH-2:0], mosi_q2};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST) begin
            rx_data_d   = sin_d;
            rx_valid_d  = 1'b1;
            word_done_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            load        = 1'b1;
            word_done_d = 1'b0;
            bit_cnt_d   = '0;
          end else begin
            sout_d = {sout_q[WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase

    // A word written in the same cycle as a load is not bypassed:
    // the load sees the old (empty) holding register.
    if (load) begin
      if (hold_full_q) begin
        sout_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        sout_d = FILL;
        unr_d  = 1'b1;
      end
    end

    if (wr) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      word_done_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      word_done_q <= word_done_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      unr_q       <= unr_d;
    end
  end

  assign spi_miso_oe  = (state_q == ACTIVE);
  assign spi_miso     = (state_q == ACTIVE) & sout_q[WIDTH-1];
  assign tx_ready     = ~hold_full_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_underrun  = unr_q;
  assign frame_active = ~ss_q3;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: vector table of single-word
// frames plus streaming, underrun, abort, reset and idle sequences.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_active;

  always #5 clk = ~clk;

  spi_slave_responder #(
    .WIDTH(8),
    .FILL (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_active(frame_active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: negedge cycle count, rx strobes and underrun pulses.
  int         cyc = 0;
  int         rxv_cnt = 0;
  int         unr_cnt = 0;
  int         rx_cyc = 0;
  int         rise_cyc = 0;
  int         unr_snap = 0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      rxv_cnt++;
      rxq.push_back(rx_data);
      rx_cyc = cyc;
    end
    if (tx_underrun) unr_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for tx_ready then writes.
  task automatic push(input logic [7:0] w);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master, 4 clk low / 4 clk high, MSB first. unr_snap is
  // taken just before the final falling edge of the transfer.
  task automatic spi_xfer(input logic [7:0] mtx, input int nbits,
                          output logic [7:0] mrx);
    mrx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mtx[7-i];
      repeat (4) @(negedge clk);
      mrx = {mrx[6:0], spi_miso};
      spi_sclk = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
      if (i == nbits - 1) unr_snap = unr_cnt;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       has_hold;
    logic [7:0] hold;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_unr;
  } vec_t;

  vec_t       vt[5];
  logic [7:0] m, m0, m1, m2, got;
  int         rv0, u0;

  initial begin
    vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
    vt[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vt[2] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1'b0};
    vt[3] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1'b1};
    vt[4] = '{1'b1, 8'h6C, 8'h96, 8'h6C, 8'h96, 1'b0};

    rst = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rxdata", {24'd0, rx_data}, 32'd0);
    chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
    chk("rst_unr", {31'd0, tx_underrun}, 32'd0);
    chk("rst_fa", {31'd0, frame_active}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      rv0 = rxv_cnt;
      u0 = unr_cnt;
      if (vt[k].has_hold) begin
        push(vt[k].hold);
        chk("ready_full", {31'd0, tx_ready}, 32'd0);
      end
      spi_ss_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("sel_oe", {31'd0, spi_miso_oe}, 32'd1);
      chk("sel_fa", {31'd0, frame_active}, 32'd1);
      chk("sel_ready", {31'd0, tx_ready}, 32'd1);
      chk("sel_msb", {31'd0, spi_miso}, {31'd0, vt[k].exp_miso[7]});
      spi_xfer(vt[k].mosi, 8, m);
      repeat (4) @(negedge clk);
      chk("vec_master_rx", {24'd0, m}, {24'd0, vt[k].exp_miso});
      chk("vec_rxv_cnt", rxv_cnt - rv0, 32'd1);
      chk("vec_rxdata", {24'd0, rx_data}, {24'd0, vt[k].exp_rx});
      chk("vec_rxv_lat", rx_cyc - rise_cyc, 32'd3);
      chk("vec_unr", unr_snap - u0, {31'd0, vt[k].exp_unr});
      frame_end();
      chk("desel_oe", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
    end

    // Streaming: three words, fabric refills as soon as ready.
    rxq.delete();
    u0 = unr_cnt;
    fork
      begin
        push(8'h01);
        push(8'h02);
        push(8'h03);
      end
      begin
        repeat (3) @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_xfer(8'h10, 8, m0);
        spi_xfer(8'h20, 8, m1);
        spi_xfer(8'h30, 8, m2);
      end
    join
    frame_end();
    chk("str_m0", {24'd0, m0}, 32'h01);
    chk("str_m1", {24'd0, m1}, 32'h02);
    chk("str_m2", {24'd0, m2}, 32'h03);
    chk("str_rx_cnt", rxq.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'hxx;
      chk("str_rx", {24'd0, got}, 32'h10 * (i + 1));
    end
    chk("str_no_unr", unr_snap - u0, 32'd0);

    // Underrun with a tx_valid landing on the load cycle itself.
    rxq.delete();
    u0 = unr_cnt;
    spi_ss_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("unr_pulse", {31'd0, tx_underrun}, 32'd1);
    chk("unr_ready", {31'd0, tx_ready}, 32'd0);
    chk("unr_msb", {31'd0, spi_miso}, 32'd1);
    @(negedge clk);
    chk("unr_pulse_end", {31'd0, tx_underrun}, 32'd0);
    spi_xfer(8'h11, 8, m);
    chk("unr_m0", {24'd0, m}, 32'hFF);
    chk("unr_cnt0", unr_snap - u0, 32'd1);
    spi_xfer(8'h22, 8, m);
    chk("unr_m1", {24'd0, m}, 32'h5A);
    chk("unr_cnt1", unr_snap - u0, 32'd1);
    frame_end();
    chk("unr_rx_cnt", rxq.size(), 32'd2);
    chk("unr_rx_last", {24'd0, rx_data}, 32'h22);

    // Abort after 5 bits; word written mid-frame must survive.
    rv0 = rxv_cnt;
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    push(8'h6B);
    spi_xfer(8'hA0, 5, m);
    frame_end();
    chk("abort_no_rxv", rxv_cnt - rv0, 32'd0);
    chk("abort_rxdata", {24'd0, rx_data}, 32'h22);
    chk("abort_hold", {31'd0, tx_ready}, 32'd0);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'hE7, 8, m);
    frame_end();
    chk("abort_next_m", {24'd0, m}, 32'h6B);
    chk("abort_next_rx", {24'd0, rx_data}, 32'hE7);
    chk("abort_next_rxv", rxv_cnt - rv0, 32'd1);

    // Async reset mid-word.
    push(8'h99);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    push(8'h77);
    spi_xfer(8'hF0, 4, m);
    spi_sclk = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_miso", {31'd0, spi_miso}, 32'd0);
    chk("arst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("arst_ready", {31'd0, tx_ready}, 32'd1);
    chk("arst_rxdata", {24'd0, rx_data}, 32'd0);
    chk("arst_rxv", {31'd0, rx_valid}, 32'd0);
    chk("arst_unr", {31'd0, tx_underrun}, 32'd0);
    chk("arst_fa", {31'd0, frame_active}, 32'd0);
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rv0 = rxv_cnt;
    push(8'h99);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'hC3, 8, m);
    frame_end();
    chk("post_rst_m", {24'd0, m}, 32'h99);
    chk("post_rst_rx", {24'd0, rx_data}, 32'hC3);
    chk("post_rst_rxv", rxv_cnt - rv0, 32'd1);

    // Idle: SCLK toggling with SS_n high.
    rv0 = rxv_cnt;
    for (int i = 0; i < 10; i++) begin
      spi_mosi = i[0];
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_pins", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
    end
    chk("idle_no_rxv", rxv_cnt - rv0, 32'd0);
    chk("idle_rxdata", {24'd0, rx_data}, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
